// File: rtl/secure_serdes_pkg.sv
// Shared definitions for the secure SerDes stream encryptor.
//   - State encoding for the top-level FSM.
//   - Default word and key widths.
//   - key_slice_count(): number of WIDTH-bit slices in a KEY_W-bit key.
package secure_serdes_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int KEY_W_DEF = 128;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_MIX  = 3'd2;
    localparam state_t ST_EMIT = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    function automatic int key_slice_count(input int key_w, input int width);
        return key_w / width;
    endfunction

endpackage

// File: rtl/serdes_key_sched.sv
// Key schedule for the stream encryptor.
// Holds the job key and presents its low WIDTH bits as the active slice.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture key into key_reg (accepted start)
//   advance    : end-of-MIX strobe; rotates key_reg right by WIDTH when rot=1
//   rot        : rotation enable latched for the current job
//   key        : key input
//   slice      : active key slice, key_reg[WIDTH-1:0]
module serdes_key_sched
    import secure_serdes_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic             rot,
    input  logic [KEY_W-1:0] key,
    output logic [WIDTH-1:0] slice
);

    localparam int N_SLICES = key_slice_count(KEY_W, WIDTH);

    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] key_rot;

    // With a single slice a rotation by WIDTH is the identity.
    generate
        if (N_SLICES > 1) begin : g_rot
            assign key_rot = {key_reg[WIDTH-1:0], key_reg[KEY_W-1:WIDTH]};
        end else begin : g_norot
            assign key_rot = key_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_reg <= '0;
        end else if (load) begin
            key_reg <= key;
        end else if (advance && rot) begin
            key_reg <= key_rot;
        end
    end

    assign slice = key_reg[WIDTH-1:0];

endmodule

// File: rtl/secure_serdes_stream_encryptor.sv
// Multi-word serial XOR stream encryptor.
// Each word: WIDTH bits of A and B are shifted in MSB-first, XORed with the
// current key slice and shifted back out MSB-first. num_words words per job.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   start, abort       : job start pulse (IDLE only), job cancel (non-IDLE)
//   key, key_rotate    : job key and per-word slice rotation enable
//   num_words          : words per job (0 means start is ignored)
//   in_valid, a_bit, b_bit : serial operand input; bit taken when in_valid & in_ready
//   in_ready           : high while in LOAD
//   cipher_out, out_valid, out_last : registered serial ciphertext
//   busy, done         : not-IDLE flag, one-cycle end-of-job pulse
// Handshake: an input bit is consumed on a rising edge where in_valid and
// in_ready are both high; there is no output backpressure.
module secure_serdes_stream_encryptor
    import secure_serdes_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int KEY_W = KEY_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key,
    input  logic             key_rotate,
    input  logic [CNT_W-1:0] num_words,
    input  logic             in_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             in_ready,
    output logic             cipher_out,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] word_sr;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] words_left;
    logic             rot_reg;
    logic [WIDTH-1:0] slice;
    logic [WIDTH-1:0] mixed;
    logic             key_load;
    logic             key_advance;

    assign key_load    = (state == ST_IDLE) && start && (num_words != '0);
    assign key_advance = (state == ST_MIX) && !abort;
    assign mixed       = a_sr ^ b_sr ^ slice;

    serdes_key_sched #(
        .WIDTH (WIDTH),
        .KEY_W (KEY_W)
    ) u_key_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (key_load),
        .advance (key_advance),
        .rot     (rot_reg),
        .key     (key),
        .slice   (slice)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            word_sr    <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            rot_reg    <= 1'b0;
            cipher_out <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            cipher_out <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (num_words != '0)) begin
                        rot_reg    <= key_rotate;
                        words_left <= num_words;
                        a_sr       <= '0;
                        b_sr       <= '0;
                        bit_cnt    <= '0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        a_sr <= {a_sr[WIDTH-2:0], a_bit};
                        b_sr <= {b_sr[WIDTH-2:0], b_bit};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_MIX;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_MIX: begin
                    // The MSB is presented on the edge entering EMIT so the
                    // output register leads word_sr by one position.
                    word_sr    <= mixed;
                    cipher_out <= mixed[WIDTH-1];
                    out_valid  <= 1'b1;
                    out_last   <= 1'b0;
                    bit_cnt    <= '0;
                    state      <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bit_cnt == BIT_LAST) begin
                        cipher_out <= 1'b0;
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        bit_cnt    <= '0;
                        words_left <= words_left - 1'b1;
                        state      <= (words_left > 1) ? ST_LOAD : ST_DONE;
                    end else begin
                        // Rotate (not shift) so word_sr[WIDTH-1] stays live;
                        // only the next-lower bit is ever emitted from here.
                        word_sr    <= {word_sr[WIDTH-2:0], word_sr[WIDTH-1]};
                        cipher_out <= word_sr[WIDTH-2];
                        out_last   <= (bit_cnt == BIT_PEN) && (words_left == 1);
                        bit_cnt    <= bit_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_secure_serdes_stream_encryptor.sv
// Directed bench for secure_serdes_stream_encryptor (WIDTH=8, KEY_W=16).
module tb_secure_serdes_stream_encryptor;

    localparam int W     = 8;
    localparam int KW    = 16;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KW-1:0] key = '0;
    logic          key_rotate = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          in_valid = 1'b0;
    logic          a_bit = 1'b0;
    logic          b_bit = 1'b0;
    logic          in_ready;
    logic          cipher_out;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;

    secure_serdes_stream_encryptor #(
        .WIDTH (W),
        .KEY_W (KW),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .key        (key),
        .key_rotate (key_rotate),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .in_ready   (in_ready),
        .cipher_out (cipher_out),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vectors = 0;
    int n_miscompares = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- output monitor ----------------
    logic [W-1:0] mon_cur = '0;
    int           mon_nbits = 0;
    logic [W-1:0] got_q[$];
    logic         got_last_q[$];
    int           done_cnt = 0;
    int           done_rel = -1;
    int           first_rel = -1;
    int           last_rel = -1;
    int           stray_cnt = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_cur = {mon_cur[W-2:0], cipher_out};
            mon_nbits = mon_nbits + 1;
            if (mon_nbits == 1) first_rel = cyc - start_cyc;
            if (out_last) last_rel = cyc - start_cyc;
            if (mon_nbits == W) begin
                got_q.push_back(mon_cur);
                got_last_q.push_back(out_last);
                mon_nbits = 0;
            end
        end else begin
            mon_nbits = 0;
            if (cipher_out || out_last) stray_cnt = stray_cnt + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_rel = cyc - start_cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [KW-1:0] k, input logic rot, input logic [CW-1:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        key = k;
        key_rotate = rot;
        num_words = n;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_word(input logic [W-1:0] a, input logic [W-1:0] b, input bit stall);
        bit ok;
        int n;
        for (int i = W - 1; i >= 0; i--) begin
            if (stall && i < W - 1) begin
                in_valid = 1'b0;
                a_bit = 1'b0;
                b_bit = 1'b0;
                @(negedge clk);
                check("ready_in_stall", 32'(in_ready), 32'd1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            n = 0;
            ok = 1'b0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!ok) check("feed_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        a_bit = 1'b0;
        b_bit = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt == base) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Compare collected words against exp_q, then clear exp_q.
    task automatic verify_job(input string tag, input int base, input int exp_done);
        int n;
        n = exp_q.size();
        check({tag, "_nwords"}, 32'(got_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_q.size()) begin
                check($sformatf("%s_word%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(got_last_q[base + i]),
                      32'(i == n - 1));
            end
        end
        check({tag, "_done_cyc"}, 32'(done_rel), 32'(exp_done));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_cipher_out"}, 32'(cipher_out), 32'd0);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_out_last"},   32'(out_last),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int dbase;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1: single word 0xA5 ^ 0x0F ^ 0x5A = 0xF0, exact timing
        base = got_q.size();
        start_job(16'h005A, 1'b0, 8'd1);
        feed_word(8'hA5, 8'h0F, 1'b0);
        exp_q.push_back(8'hF0);
        wait_done(100);
        check("t1_first_bit_cyc", 32'(first_rel), 32'd10);
        check("t1_last_cyc", 32'(last_rel), 32'd17);
        verify_job("t1", base, 18);

        // T2: rotating key, three words, slice wraps after two
        base = got_q.size();
        start_job(16'h3C5A, 1'b1, 8'd3);
        for (int i = 0; i < 3; i++) feed_word(8'h00, 8'h00, 1'b0);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        wait_done(200);
        check("t2_last_cyc", 32'(last_rel), 32'd51);
        verify_job("t2", base, 52);

        // T3: same job with static slice
        base = got_q.size();
        start_job(16'h3C5A, 1'b0, 8'd3);
        for (int i = 0; i < 3; i++) feed_word(8'h00, 8'h00, 1'b0);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        wait_done(200);
        verify_job("t3", base, 52);

        // T4: in_valid stalls between bits; 0xFF ^ 0x00 ^ 0x0F = 0xF0
        base = got_q.size();
        start_job(16'h000F, 1'b0, 8'd1);
        feed_word(8'hFF, 8'h00, 1'b1);
        exp_q.push_back(8'hF0);
        wait_done(100);
        verify_job("t4", base, 25);

        // T5: abort while the fourth output bit is on the line
        base = got_q.size();
        dbase = done_cnt;
        start_job(16'h005A, 1'b0, 8'd1);
        feed_word(8'hA5, 8'h0F, 1'b0);
        n = 0;
        while (mon_nbits != 3 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached_bit3", 32'(mon_nbits), 32'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        check("t5_no_done", 32'(done_cnt - dbase), 32'd0);
        check("t5_no_word", 32'(got_q.size() - base), 32'd0);

        // T5b: normal job right after the abort
        base = got_q.size();
        start_job(16'h005A, 1'b0, 8'd1);
        feed_word(8'hA5, 8'h0F, 1'b0);
        exp_q.push_back(8'hF0);
        wait_done(100);
        verify_job("t5b", base, 18);

        // T6: start with num_words=0 is ignored
        dbase = done_cnt;
        start_job(16'h1234, 1'b0, 8'd0);
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #2;
        check("t6_no_done", 32'(done_cnt - dbase), 32'd0);

        // T7: start, key and num_words change mid-job have no effect
        base = got_q.size();
        start_job(16'h005A, 1'b0, 8'd2);
        feed_word(8'h12, 8'h34, 1'b0);
        start = 1'b1;
        key = 16'hFFFF;
        key_rotate = 1'b1;
        num_words = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        feed_word(8'hFF, 8'h00, 1'b0);
        exp_q.push_back(8'h7C);
        exp_q.push_back(8'hA5);
        wait_done(200);
        verify_job("t7", base, 35);
        @(negedge clk);
        check("t7_idle_after", 32'(busy), 32'd0);

        // T8: reset in the middle of LOAD
        start_job(16'h005A, 1'b0, 8'd1);
        in_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("t8");
        in_valid = 1'b0;
        a_bit = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T8b: recovery after reset
        base = got_q.size();
        start_job(16'h005A, 1'b0, 8'd1);
        feed_word(8'hA5, 8'h0F, 1'b0);
        exp_q.push_back(8'hF0);
        wait_done(100);
        verify_job("t8b", base, 18);

        check("stray_cipher", 32'(stray_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/secure_serdes_stream_encryptor.md
Name: secure_serdes_stream_encryptor

Overview:
- Parametrised, multi-word successor to the single-byte serial XOR encryptor in the secure SerDes path.
- Deserialises two WIDTH-bit operand words (a_bit, b_bit), XORs them with a key slice, and reserialises the ciphertext MSB-first.
- Repeats this for num_words words per start command.
- Adds: input valid/ready handshake, optional per-word key-slice rotation, abort, and last/busy/done status.

Parameters:
- WIDTH, 8: bits per word; must be ≥2.
- KEY_W, 128: key width; must be a multiple of WIDTH.
- CNT_W, 8: width of the num_words field.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a job when in IDLE.
- abort  in  1  synchronous job cancel.
- key  in  KEY_W  key; sampled on accepted start.
- key_rotate  in  1  0 = static slice key[WIDTH-1:0]; 1 = rotate slice per word. Sampled on accepted start.
- num_words  in  CNT_W  words per job; sampled on accepted start; 0 = start ignored.
- in_valid  in  1  a_bit/b_bit valid this cycle.
- a_bit  in  1  operand A serial bit, MSB first.
- b_bit  in  1  operand B serial bit, MSB first.
- in_ready  out  1  high only in LOAD.
- cipher_out  out  1  ciphertext bit, MSB first.
- out_valid  out  1  cipher_out valid.
- out_last  out  1  with the final bit of the final word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; all outputs and internal registers 0. Takes priority over everything, including mid-job.
- States: IDLE, LOAD, MIX, EMIT, DONE.
- IDLE:
  - start=1 and num_words≠0: latch key_reg=key, rot_reg=key_rotate, words_left=num_words, clear A, B and bit_cnt; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: in_ready=1. On in_valid=1, A<={A[W-2:0],a_bit}, B<={B[W-2:0],b_bit}, bit_cnt++. After the WIDTH-th accepted bit, go to MIX. in_valid=0 cycles stall with no state change.
- MIX (1 cycle):
  - word_sr = A ^ B ^ key_reg[WIDTH-1:0]; bit_cnt=0.
  - If rot_reg=1, rotate key_reg right by WIDTH. Slices therefore cycle key[W-1:0], key[2W-1:W], …, and wrap to slice 0 after KEY_W/WIDTH words.
  - Go to EMIT.
- EMIT:
  - Registered outputs: cipher_out and out_valid=1 for exactly WIDTH consecutive cycles, starting the cycle after MIX. Bit order word_sr[W-1] down to word_sr[0].
  - out_last=1 only on bit 0 of the word for which words_left=1.
  - After the last bit, words_left--. If words_left>0 (pre-decrement value >1), go to LOAD; else go to DONE.
  - No output backpressure.
- DONE: done=1 for one cycle, busy=1; next cycle go to IDLE.
- Latency with in_valid held high: start at cycle 0; bits captured cycles 1..W; MIX at cycle W+1; ciphertext cycles W+2..2W+1; done at 2W+2.
- Per additional word: 2W+1 cycles (W LOAD + 1 MIX + W EMIT).
- out_valid is 0 outside EMIT; cipher_out is 0 when out_valid=0.
- abort=1 in any non-IDLE state: next state IDLE, outputs cleared, done not pulsed, in-flight word discarded. abort in IDLE has no effect.
- Simultaneous events:
  - abort and start together in IDLE: start wins.
  - start while busy: ignored.
  - key, key_rotate or num_words changing mid-job: no effect.
- Counters:
  - bit_cnt width $clog2(WIDTH), compared to WIDTH-1 (no reliance on natural wrap).
  - words_left is CNT_W bits; a maximum of 2^CNT_W−1 words is supported.
- Decryption is the same operation (XOR is symmetric); no separate mode.

Decomposition:
- Package secure_serdes_pkg holds:
  - state enum (IDLE/LOAD/MIX/EMIT/DONE);
  - default localparams WIDTH_DEF=8, KEY_W_DEF=128;
  - a function key_slice_count(KEY_W, WIDTH).
- One sub-module, serdes_key_sched:
  - holds key_reg;
  - loads it on start, rotates it on advance when rot=1;
  - presents slice[WIDTH-1:0].
- The FSM, shift registers and counters stay in the top module.

Test Plan:
- WIDTH=8, key[7:0]=0x5A, key_rotate=0, num_words=1, A=0xA5, B=0x0F streamed with in_valid held high -> cipher bits 1111_0000 (0xF0) on cycles 10..17, out_last on cycle 17, done on cycle 18.
- key[15:0]=0x3C5A, key_rotate=1, num_words=3, KEY_W=16, A=B=0 -> words 0x5A, 0x3C, 0x5A (slice wrap); out_last only on the third word.
- Same job with key_rotate=0 -> 0x5A, 0x5A, 0x5A.
- in_valid toggling 1/0 during LOAD with A=0xFF, B=0x00, key slice 0x0F -> output 0xF0 appears unchanged, just delayed by the stall cycles; in_ready=1 throughout LOAD.
- abort during EMIT bit 3 -> out_valid=0 next cycle, busy=0, no done pulse. A following start then runs normally.
- Control corner cases:
  - start with num_words=0 -> busy stays 0.
  - start pulsed mid-job -> ignored.
  - rst_n=0 mid-LOAD -> every output is 0 on the next edge.
